mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 127 ++++++++++++
 tb/tb_mdu_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide controller: computes the result at issue, then holds it in
// temp registers across a fixed-latency busy window before committing to HI/LO.
module mdu_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        E_md_start,
   input  logic [2:0]  E_md_op,
   input  logic [31:0] E_GRF_RD1,
   input  logic [31:0] E_GRF_RD2,
   input  logic        req,
   input  logic        D_md_use,
   output logic        busy,
   output logic        md_stall,
   output logic        done,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] MUL_CNT = CW'(4);
   localparam logic [CW-1:0] DIV_CNT = CW'(9);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic            done_q;
   logic            div0_q;
   logic [W-1:0]    hi_q, lo_q;
   logic [W-1:0]    tmp_hi_q, tmp_lo_q;

   logic            accept_c;
   logic [2*W-1:0]  mul_s_c, mul_u_c;
   logic            is_signed_c, a_neg_c, b_neg_c;
   logic [W-1:0]    abs_a_c, abs_b_c, dvs_c, q_mag_c, r_mag_c, quo_c, rem_c;

   // Issue qualification and result datapath (evaluated in the issue cycle only)
   always_comb begin
      accept_c    = (state_q == S_IDLE) && E_md_start && !req && (E_md_op <= OP_MTLO);
      mul_u_c     = {{W{1'b0}}, E_GRF_RD1} * {{W{1'b0}}, E_GRF_RD2};
      mul_s_c     = {{W{E_GRF_RD1[W-1]}}, E_GRF_RD1} * {{W{E_GRF_RD2[W-1]}}, E_GRF_RD2};
      is_signed_c = (E_md_op == OP_DIV);
      a_neg_c     = is_signed_c & E_GRF_RD1[W-1];
      b_neg_c     = is_signed_c & E_GRF_RD2[W-1];
      abs_a_c     = a_neg_c ? W'(-E_GRF_RD1) : E_GRF_RD1;
      abs_b_c     = b_neg_c ? W'(-E_GRF_RD2) : E_GRF_RD2;
      // Divisor forced non-zero; a zero divisor is flagged and the commit suppressed
      dvs_c       = (abs_b_c == '0) ? W'(1) : abs_b_c;
      q_mag_c     = abs_a_c / dvs_c;
      r_mag_c     = abs_a_c % dvs_c;
      quo_c       = (a_neg_c ^ b_neg_c) ? W'(-q_mag_c) : q_mag_c;
      rem_c       = a_neg_c ? W'(-r_mag_c) : r_mag_c;
   end

   assign md_stall = D_md_use & (busy_q | (E_md_start & (E_md_op <= OP_DIVU)));
   assign busy     = busy_q;
   assign done     = done_q;
   assign HI       = hi_q;
   assign LO       = lo_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         div0_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         tmp_hi_q <= '0;
         tmp_lo_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept_c) begin
                  case (E_md_op)
                     OP_MULT, OP_MULTU: begin
                        state_q  <= S_MUL;
                        cnt_q    <= MUL_CNT;
                        busy_q   <= 1'b1;
                        div0_q   <= 1'b0;
                        {tmp_hi_q, tmp_lo_q} <= (E_md_op == OP_MULT) ? mul_s_c : mul_u_c;
                     end
                     OP_DIV, OP_DIVU: begin
                        state_q  <= S_DIV;
                        cnt_q    <= DIV_CNT;
                        busy_q   <= 1'b1;
                        div0_q   <= (E_GRF_RD2 == '0);
                        tmp_hi_q <= rem_c;
                        tmp_lo_q <= quo_c;
                     end
                     OP_MTHI: hi_q <= E_GRF_RD1;
                     OP_MTLO: lo_q <= E_GRF_RD1;
                     default: ;
                  endcase
               end
            end
            S_MUL, S_DIV: begin
               // Runs to completion regardless of req or new starts
               if (cnt_q == '0) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  if (!div0_q) begin
                     hi_q <= tmp_hi_q;
                     lo_q <= tmp_lo_q;
                  end
               end else begin
                  cnt_q  <= CW'(cnt_q - 1'b1);
                  done_q <= (cnt_q == CW'(1));
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO queued at issue, compared after done.
module tb_mdu_ctrl;

   logic        clk;
   logic        reset;
   logic        E_md_start;
   logic [2:0]  E_md_op;
   logic [31:0] E_GRF_RD1, E_GRF_RD2;
   logic        req;
   logic        D_md_use;
   logic        busy, md_stall, done;
   logic [31:0] HI, LO;

   int checks;
   int errors;
   logic [63:0] exp_q[$];
   logic [31:0] m_hi, m_lo;

   mdu_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .E_md_start (E_md_start),
      .E_md_op    (E_md_op),
      .E_GRF_RD1  (E_GRF_RD1),
      .E_GRF_RD2  (E_GRF_RD2),
      .req        (req),
      .D_md_use   (D_md_use),
      .busy       (busy),
      .md_stall   (md_stall),
      .done       (done),
      .HI         (HI),
      .LO         (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour built on 64-bit signed arithmetic
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: model = 64'(sa * sb);
         3'd1: model = {32'b0, a} * {32'b0, b};
         3'd2: begin
            if (b == 32'd0) model = {m_hi, m_lo};
            else begin
               q = 64'(sa / sb);
               r = 64'(sa % sb);
               model = {r[31:0], q[31:0]};
            end
         end
         3'd3: model = (b == 32'd0) ? {m_hi, m_lo} : {a % b, a / b};
         3'd4: model = {a, m_lo};
         3'd5: model = {m_hi, a};
         default: model = {m_hi, m_lo};
      endcase
   endfunction

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input logic use_d, input int req_at, input int start_at);
      logic [63:0] e, got;
      int nbusy, done_at, ndone;
      e = model(op, a, b);
      if (exp_busy > 0) exp_q.push_back(e);
      E_md_op    = op;
      E_GRF_RD1  = a;
      E_GRF_RD2  = b;
      E_md_start = 1'b1;
      D_md_use   = use_d;
      #1;
      chk("stall_issue", 64'(md_stall), 64'(use_d & (op <= 3'd3)));
      tick();
      E_md_start = 1'b0;
      if (exp_busy == 0) begin
         chk("no_busy", 64'(busy), 64'd0);
         chk("mt_hilo", {HI, LO}, e);
         {m_hi, m_lo} = e;
         D_md_use = 1'b0;
         return;
      end
      nbusy = 0; done_at = 0; ndone = 0;
      for (int c = 1; c <= 20; c++) begin
         E_GRF_RD1  = $urandom;
         E_GRF_RD2  = $urandom;
         req        = (c == req_at);
         E_md_start = (c == start_at);
         E_md_op    = 3'd0;
         #1;
         if (!busy) break;
         nbusy++;
         if (done) begin done_at = c; ndone++; end
         chk("stall_busy", 64'(md_stall), 64'(use_d));
         tick();
      end
      req = 1'b0;
      E_md_start = 1'b0;
      chk("busy_len", 64'(nbusy), 64'(exp_busy));
      chk("done_cyc", 64'(done_at), 64'(exp_busy));
      chk("done_cnt", 64'(ndone), 64'd1);
      chk("stall_after", 64'(md_stall), 64'd0);
      if (exp_q.size() == 0) begin
         chk("sb_empty", 64'd0, 64'd1);
      end else begin
         got = exp_q.pop_front();
         chk("hilo", {HI, LO}, got);
         {m_hi, m_lo} = got;
      end
      D_md_use = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      m_hi = '0; m_lo = '0;
      reset = 1'b0; E_md_start = 1'b0; E_md_op = '0;
      E_GRF_RD1 = '0; E_GRF_RD2 = '0; req = 1'b0; D_md_use = 1'b0;
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hilo", {HI, LO}, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 0, 0);
      do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b1, 0, 0);
      do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 0, 0);
      do_op(3'd3, 32'd1234, 32'd0, 10, 1'b1, 0, 0);
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 0, 3);
      do_op(3'd2, 32'd7, 32'hFFFF_FFFE, 10, 1'b0, 0, 0);
      do_op(3'd2, 32'd5, 32'd0, 10, 1'b0, 0, 0);
      do_op(3'd3, 32'hF000_0001, 32'd16, 10, 1'b0, 0, 0);
      do_op(3'd0, 32'h8000_0000, 32'h8000_0000, 5, 1'b0, 2, 0);
      do_op(3'd4, 32'hDEAD_BEEF, 32'd0, 0, 1'b1, 0, 0);
      do_op(3'd5, 32'hCAFE_F00D, 32'd0, 0, 1'b0, 0, 0);
      do_op(3'd6, 32'h1111_1111, 32'd3, 0, 1'b0, 0, 0);
      do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b1, 0, 2);
      for (int i = 0; i < 4; i++)
         do_op(3'(i), $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom, (i < 2) ? 5 : 10, 1'b0, 0, 0);

      // Flushed start: req in the same cycle suppresses the issue
      E_md_op = 3'd0; E_GRF_RD1 = 32'd9; E_GRF_RD2 = 32'd9;
      E_md_start = 1'b1; req = 1'b1;
      tick();
      E_md_start = 1'b0; req = 1'b0;
      chk("req_no_busy", 64'(busy), 64'd0);
      tick();
      chk("req_no_busy2", 64'(busy), 64'd0);
      chk("req_hilo", {HI, LO}, {m_hi, m_lo});

      // Asynchronous reset in the middle of a divide
      E_md_op = 3'd2; E_GRF_RD1 = 32'd100; E_GRF_RD2 = 32'd7; E_md_start = 1'b1;
      tick();
      E_md_start = 1'b0;
      tick(); tick();
      chk("pre_rst_busy", 64'(busy), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_hilo", {HI, LO}, 64'd0);
      m_hi = '0; m_lo = '0;
      tick(); tick();
      @(negedge clk);
      reset = 1'b1;
      begin
         int ndone;
         ndone = 0;
         for (int c = 0; c < 14; c++) begin
            tick();
            if (done || busy) ndone++;
         end
         chk("no_done_after_rst", 64'(ndone), 64'd0);
         chk("post_rst_hilo", {HI, LO}, 64'd0);
      end

      // Start on the first edge after release
      @(posedge clk); #1;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      do_op(3'd0, 32'd3, 32'hFFFF_FFFB, 5, 1'b0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
